pes_fb_piso_param: RTL and testbench
====================================

// Module: pes_fb_piso_param
// PURPOSE
//   Parametrised parallel-in/serial-out shifter with a load/ready handshake.
//   Captures a WIDTH-bit word and emits it one bit per clock, MSB- or LSB-first.
//   Frame markers frame_start/frame_end accompany the stream.
//   Accepting a new word on the last bit gives gapless back-to-back frames.
//   Feeds serial links / bit-banged outputs; replaces the fixed 4-bit PISO.
// PARAMETERS
//   WIDTH      8   parallel word width in bits; must be >= 2
//   MSB_FIRST  1   1: data_in[WIDTH-1] is sent first; 0: data_in[0] is sent first
//   IDLE_LEVEL 0   value driven on data_out when no frame is active
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous reset, active-high
//   load         in   1      request to accept data_in this cycle
//   data_in      in   WIDTH  parallel word, sampled only on accept
//   ready        out  1      block can accept a word this cycle
//   data_out     out  1      serial bit (registered)
//   out_valid    out  1      data_out carries a frame bit (registered)
//   frame_start  out  1      high with bit 0 of each frame (registered)
//   frame_end    out  1      high with bit WIDTH-1 of each frame (registered)
//   bit_idx      out  $clog2(WIDTH)  index of the bit currently on data_out
// BEHAVIOUR
//   Reset (rst=1 at an edge, highest priority):
//     state=IDLE, data_out=IDLE_LEVEL, out_valid=0, frame_start=0, frame_end=0, bit_idx=0.
//     A frame in flight is aborted; no further bits of it are emitted.
//   States: IDLE, SHIFT. accept = load & ready.
//   ready (combinational from registers) = (state==IDLE) | (state==SHIFT & bit_idx==WIDTH-1).
//   IDLE: on accept -> SHIFT; shift reg <= data_in; data_out <= first bit;
//     out_valid=1, frame_start=1, bit_idx=0. Without accept: outputs hold idle values.
//   Latency: first bit appears on data_out in the cycle after the accepting edge.
//   SHIFT, bit_idx<WIDTH-1: each edge bit_idx+1, data_out <= next bit in order,
//     frame_start=0. frame_end=1 exactly when the new bit_idx==WIDTH-1.
//     load is ignored (ready=0); data_in is not sampled.
//   SHIFT, bit_idx==WIDTH-1 (last bit on data_out):
//     accept  -> stay SHIFT, reload as in IDLE: no idle cycle between frames.
//     no load -> IDLE; data_out=IDLE_LEVEL, out_valid=0, frame_end=0.
//   Bit order: MSB_FIRST=1 sends data_in[WIDTH-1] down to [0];
//     MSB_FIRST=0 sends [0] up to [WIDTH-1].
//   Each frame is exactly WIDTH cycles with out_valid=1.
//   frame_start and frame_end are each high for one cycle per frame.
//   Shift register contents are don't-care once the frame completes.
//   Invariant: out_valid=0 implies data_out==IDLE_LEVEL.
//   Simultaneous rst and load: reset wins; the word is not accepted.
// TESTING
//   1 WIDTH=4, MSB_FIRST=1, load data_in=4'b1011 once from idle -> data_out 1,0,1,1;
//     then IDLE_LEVEL; out_valid high exactly 4 cycles; frame_start cycle 1, frame_end cycle 4.
//   2 WIDTH=4, MSB_FIRST=0, data_in=4'b1011 -> data_out 1,1,0,1.
//   3 WIDTH=8, MSB_FIRST=1, load 8'hA5, hold load high with 8'h3C at the last bit
//     -> 16 contiguous valid bits 1010_0101_0011_1100, no gap; frame_start at bits 0 and 8.
//   4 WIDTH=8, load 8'hFF, then pulse load with 8'h00 at bit_idx=3 -> ignored;
//     eight 1s emitted, then idle; ready=0 throughout bit_idx 0..6.
//   5 WIDTH=8, load 8'hF0; assert rst at bit_idx=2
//     -> next cycle out_valid=0, data_out=IDLE_LEVEL, ready=1; next load starts a clean frame.
//   6 IDLE_LEVEL=1, WIDTH=4, load 4'b0000 -> data_out 1 (idle), 0,0,0,0, then back to 1.

Source files
------------

// File: rtl/pes_fb_piso_param.sv
// Parallel-in/serial-out shifter with load/ready handshake and frame markers.
// A word loaded on the last bit of a frame continues the stream with no idle gap.
module pes_fb_piso_param #(
   parameter int   WIDTH      = 8,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [WIDTH-1:0]         data_in,
   output logic                     ready,
   output logic                     data_out,
   output logic                     out_valid,
   output logic                     frame_start,
   output logic                     frame_end,
   output logic [$clog2(WIDTH)-1:0] bit_idx
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic             accept;
   logic             at_last;
   logic [IW-1:0]    idx_nxt;

   assign at_last = (bit_idx == LAST);
   assign ready   = (state == IDLE) | ((state == SHIFT) & at_last);
   assign accept  = load & ready;
   assign idx_nxt = bit_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         data_out    <= IDLE_LEVEL;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         bit_idx     <= '0;
      end else if (accept) begin
         // The first bit goes straight to data_out; shreg keeps the remainder.
         state       <= SHIFT;
         data_out    <= MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
         shreg       <= MSB_FIRST ? (data_in << 1) : (data_in >> 1);
         out_valid   <= 1'b1;
         frame_start <= 1'b1;
         frame_end   <= 1'b0;
         bit_idx     <= '0;
      end else if (state == SHIFT && !at_last) begin
         data_out    <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
         shreg       <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
         frame_start <= 1'b0;
         frame_end   <= (idx_nxt == LAST);
         bit_idx     <= idx_nxt;
      end else begin
         state       <= IDLE;
         data_out    <= IDLE_LEVEL;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         bit_idx     <= '0;
      end
   end

endmodule

// File: tb/tb_pes_fb_piso_param.sv
// Directed bench for pes_fb_piso_param across four parameter sets.
module tb_pes_fb_piso_param;

   logic       clk = 1'b0;
   logic       rs   [4];
   logic       ld   [4];
   logic [7:0] din  [4];
   logic       rdy  [4];
   logic       dout [4];
   logic       ov   [4];
   logic       fs   [4];
   logic       fe   [4];
   logic [1:0] bi0, bi1, bi3;
   logic [2:0] bi2;
   logic [2:0] bidx [4];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign bidx[0] = {1'b0, bi0};
   assign bidx[1] = {1'b0, bi1};
   assign bidx[2] = bi2;
   assign bidx[3] = {1'b0, bi3};

   pes_fb_piso_param #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
      .clk(clk), .rst(rs[0]), .load(ld[0]), .data_in(din[0][3:0]), .ready(rdy[0]),
      .data_out(dout[0]), .out_valid(ov[0]), .frame_start(fs[0]), .frame_end(fe[0]), .bit_idx(bi0));
   pes_fb_piso_param #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
      .clk(clk), .rst(rs[1]), .load(ld[1]), .data_in(din[1][3:0]), .ready(rdy[1]),
      .data_out(dout[1]), .out_valid(ov[1]), .frame_start(fs[1]), .frame_end(fe[1]), .bit_idx(bi1));
   pes_fb_piso_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u2 (
      .clk(clk), .rst(rs[2]), .load(ld[2]), .data_in(din[2]), .ready(rdy[2]),
      .data_out(dout[2]), .out_valid(ov[2]), .frame_start(fs[2]), .frame_end(fe[2]), .bit_idx(bi2));
   pes_fb_piso_param #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u3 (
      .clk(clk), .rst(rs[3]), .load(ld[3]), .data_in(din[3][3:0]), .ready(rdy[3]),
      .data_out(dout[3]), .out_valid(ov[3]), .frame_start(fs[3]), .frame_end(fe[3]), .bit_idx(bi3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input int k, input logic lvl, input string tag);
      chk({tag, " idle out_valid"}, 32'(ov[k]), 32'd0);
      chk({tag, " idle data_out"}, 32'(dout[k]), 32'(lvl));
      chk({tag, " idle frame_end"}, 32'(fe[k]), 32'd0);
      chk({tag, " idle ready"}, 32'(rdy[k]), 32'd1);
      chk({tag, " idle bit_idx"}, 32'(bidx[k]), 32'd0);
   endtask

   // Caller raises ld[k]; the bench drops it after the accepting edge.
   task automatic run_frame(input int k, input int w, input logic [15:0] bits, input string tag);
      for (int i = 0; i < w; i++) begin
         tick();
         if (i == 0) ld[k] = 1'b0;
         chk($sformatf("%s bit%0d data", tag, i), 32'(dout[k]), 32'(bits[w-1-i]));
         chk($sformatf("%s bit%0d valid", tag, i), 32'(ov[k]), 32'd1);
         chk($sformatf("%s bit%0d start", tag, i), 32'(fs[k]), 32'(i == 0));
         chk($sformatf("%s bit%0d end", tag, i), 32'(fe[k]), 32'(i == w - 1));
         chk($sformatf("%s bit%0d idx", tag, i), 32'(bidx[k]), 32'(i));
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         rs[k] = 1'b1; ld[k] = 1'b0; din[k] = 8'h00;
      end
      tick(); tick();
      for (int k = 0; k < 4; k++) rs[k] = 1'b0;
      tick();
      chk_idle(0, 1'b0, "reset u0");
      chk_idle(2, 1'b0, "reset u2");
      chk("reset u3 data_out", 32'(dout[3]), 32'd1);

      // W4 MSB-first 1011 -> 1,0,1,1
      din[0] = 8'h0B; ld[0] = 1'b1;
      run_frame(0, 4, 16'b1011, "t1");
      tick();
      chk_idle(0, 1'b0, "t1");

      // W4 LSB-first 1011 -> 1,1,0,1
      din[1] = 8'h0B; ld[1] = 1'b1;
      run_frame(1, 4, 16'b1101, "t2");
      tick();
      chk_idle(1, 1'b0, "t2");

      // W8 back-to-back A5 then 3C with load held high
      din[2] = 8'hA5; ld[2] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0) din[2] = 8'h3C;
         if (i == 8) ld[2] = 1'b0;
         chk($sformatf("t3 bit%0d data", i), 32'(dout[2]), 32'(i < 8 ? (8'hA5 >> (7 - i)) & 1 : (8'h3C >> (15 - i)) & 1));
         chk($sformatf("t3 bit%0d valid", i), 32'(ov[2]), 32'd1);
         chk($sformatf("t3 bit%0d start", i), 32'(fs[2]), 32'(i == 0 || i == 8));
         chk($sformatf("t3 bit%0d end", i), 32'(fe[2]), 32'(i == 7 || i == 15));
         chk($sformatf("t3 bit%0d ready", i), 32'(rdy[2]), 32'(i == 7 || i == 15));
      end
      tick();
      chk_idle(2, 1'b0, "t3");

      // W8 FF with a load pulse of 00 at bit_idx 3 that must be ignored
      din[2] = 8'hFF; ld[2] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         ld[2] = (i == 3);
         din[2] = (i == 3) ? 8'h00 : 8'hFF;
         chk($sformatf("t4 bit%0d data", i), 32'(dout[2]), 32'd1);
         chk($sformatf("t4 bit%0d idx", i), 32'(bidx[2]), 32'(i));
         chk($sformatf("t4 bit%0d ready", i), 32'(rdy[2]), 32'(i == 7));
      end
      ld[2] = 1'b0;
      tick();
      chk_idle(2, 1'b0, "t4");

      // W8 F0 aborted by reset at bit_idx 2, then a clean 81 frame
      din[2] = 8'hF0; ld[2] = 1'b1;
      tick(); ld[2] = 1'b0;
      tick(); tick();
      chk("t5 pre-reset idx", 32'(bidx[2]), 32'd2);
      rs[2] = 1'b1;
      tick();
      rs[2] = 1'b0;
      chk_idle(2, 1'b0, "t5");
      tick();
      chk("t5 stays idle", 32'(ov[2]), 32'd0);
      din[2] = 8'h81; ld[2] = 1'b1;
      run_frame(2, 8, 16'h0081, "t5b");
      tick();
      chk_idle(2, 1'b0, "t5b");

      // Reset and load together on u0: the word is not accepted
      rs[0] = 1'b1; ld[0] = 1'b1; din[0] = 8'h0F;
      tick();
      rs[0] = 1'b0; ld[0] = 1'b0;
      chk("rst+load valid", 32'(ov[0]), 32'd0);
      tick();
      chk("rst+load after", 32'(ov[0]), 32'd0);

      // IDLE_LEVEL=1, W4 zeros
      chk("t6 idle high", 32'(dout[3]), 32'd1);
      din[3] = 8'h00; ld[3] = 1'b1;
      run_frame(3, 4, 16'b0000, "t6");
      tick();
      chk_idle(3, 1'b1, "t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
